dcache_ctrl: RTL and testbench

Two-way set-associative data-cache controller sitting between the CPU memory stage and the off-chip data memory. It owns the tag/data arrays, resolves hit and way select, maintains per-set LRU, stalls the CPU on a miss and sequences write-back of a dirty victim followed by line refill. The cache uses write-back and write-allocate.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_if.sv | 29 ++
 rtl/dcache_sram.sv | 66 ++++++
 rtl/dcache_ctrl.sv | 98 +++++++++
 tb/tb_dcache_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, tag-entry layout and FSM encoding for the two-way data cache.
package dcache_pkg;
   localparam int SETS      = 16;
   localparam int IDX_W     = 4;
   localparam int LINE_BITS = 256;
   localparam int TAG_W     = 23;
   localparam int WORD_W    = 3;
   localparam int ENTRY_W   = TAG_W + 2;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   function automatic logic [ENTRY_W-1:0] make_entry(input logic valid, input logic dirty,
                                                     input logic [TAG_W-1:0] tag);
      return {valid, dirty, tag};
   endfunction
endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bundles of the data cache; port names follow the cache's view.
interface dcache_cpu_if;
   logic        cpu_req_i;
   logic        cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        cpu_stall_o;

   modport master (output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
                   input  cpu_data_o, cpu_stall_o);
   modport slave  (input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
                   output cpu_data_o, cpu_stall_o);
endinterface

interface dcache_mem_if;
   import dcache_pkg::*;
   logic                 mem_enable_o;
   logic                 mem_write_o;
   logic [31:0]          mem_addr_o;
   logic [LINE_BITS-1:0] mem_data_o;
   logic [LINE_BITS-1:0] mem_data_i;
   logic                 mem_ack_i;

   modport master (output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
                   input  mem_data_i, mem_ack_i);
   modport slave  (input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
                   output mem_data_i, mem_ack_i);
endinterface

// File: rtl/dcache_sram.sv
// Two-way tag/data storage with LRU bits: async read, sync write, hit compare and word merge.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [IDX_W-1:0]          idx_i,
   input  logic [TAG_W-1:0]          tag_i,
   input  logic [WORD_W-1:0]         word_i,
   input  logic                      access_i,
   input  logic                      we_i,
   input  logic [31:0]               wdata_i,
   input  logic                      fill_i,
   input  logic                      fill_way_i,
   input  logic [LINE_BITS-1:0]      fill_data_i,
   output logic [1:0]                hit_o,
   output logic [31:0]               rdata_o,
   output logic [1:0]                valid_o,
   output logic [1:0]                dirty_o,
   output logic [1:0][TAG_W-1:0]     tag_o,
   output logic [1:0][LINE_BITS-1:0] line_o,
   output logic                      lru_o
);
   logic [ENTRY_W-1:0]   tag_q  [2][SETS];
   logic [LINE_BITS-1:0] data_q [2][SETS];
   logic [SETS-1:0]      lru_q;
   logic                 hit_way;

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         valid_o[w] = tag_q[w][idx_i][VALID_BIT];
         dirty_o[w] = tag_q[w][idx_i][DIRTY_BIT];
         tag_o[w]   = tag_q[w][idx_i][TAG_W-1:0];
         line_o[w]  = data_q[w][idx_i];
         hit_o[w]   = valid_o[w] && (tag_o[w] == tag_i);
      end
      // way 0 wins if both ever match
      hit_way = !hit_o[0];
      rdata_o = data_q[hit_way][idx_i][word_i*32 +: 32];
      lru_o   = lru_q[idx_i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++)
               tag_q[w][s] <= '0;
         lru_q <= '0;
      end else if (fill_i) begin
         tag_q[fill_way_i][idx_i] <= make_entry(1'b1, 1'b0, tag_i);
      end else if (access_i) begin
         lru_q[idx_i] <= ~hit_way;
         if (we_i)
            tag_q[hit_way][idx_i][DIRTY_BIT] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_i)
         data_q[fill_way_i][idx_i] <= fill_data_i;
      else if (access_i && we_i)
         data_q[hit_way][idx_i][word_i*32 +: 32] <= wdata_i;
   end

   assert property (@(posedge clk_i) disable iff (rst_i) !(hit_o[0] && hit_o[1]));
endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate data-cache controller: miss FSM, victim latch and memory-port muxing.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   dcache_cpu_if.slave  cpu,
   dcache_mem_if.master mem
);
   state_e                    state_q, state_d;
   logic                      victim_q, victim_d;
   logic                      access, fill, hit, lru;
   logic [1:0]                hit_w, valid_w, dirty_w;
   logic [1:0][TAG_W-1:0]     tag_w;
   logic [1:0][LINE_BITS-1:0] line_w;
   logic [31:0]               rdata;
   logic [IDX_W-1:0]          idx;
   logic                      addr_lsb_unused;

   assign idx             = cpu.cpu_addr_i[8:5];
   assign hit             = |hit_w;
   assign addr_lsb_unused = ^cpu.cpu_addr_i[1:0];

   dcache_sram u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .idx_i       (idx),
      .tag_i       (cpu.cpu_addr_i[31:9]),
      .word_i      (cpu.cpu_addr_i[4:2]),
      .access_i    (access),
      .we_i        (cpu.cpu_we_i),
      .wdata_i     (cpu.cpu_data_i),
      .fill_i      (fill),
      .fill_way_i  (victim_q),
      .fill_data_i (mem.mem_data_i),
      .hit_o       (hit_w),
      .rdata_o     (rdata),
      .valid_o     (valid_w),
      .dirty_o     (dirty_w),
      .tag_o       (tag_w),
      .line_o      (line_w),
      .lru_o       (lru)
   );

   always_comb begin
      state_d          = state_q;
      victim_d         = victim_q;
      access           = 1'b0;
      fill             = 1'b0;
      cpu.cpu_stall_o  = 1'b1;
      cpu.cpu_data_o   = '0;
      mem.mem_enable_o = 1'b0;
      mem.mem_write_o  = 1'b0;
      mem.mem_addr_o   = '0;
      mem.mem_data_o   = '0;
      unique case (state_q)
         IDLE: begin
            cpu.cpu_stall_o = cpu.cpu_req_i && !hit;
            if (cpu.cpu_req_i && hit) begin
               access         = 1'b1;
               cpu.cpu_data_o = rdata;
            end else if (cpu.cpu_req_i) begin
               // prefer an empty way; otherwise evict the least recently used one
               if (!valid_w[0])      victim_d = 1'b0;
               else if (!valid_w[1]) victim_d = 1'b1;
               else                  victim_d = lru;
               state_d = (valid_w[victim_d] && dirty_w[victim_d]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem.mem_enable_o = 1'b1;
            mem.mem_write_o  = 1'b1;
            mem.mem_addr_o   = {tag_w[victim_q], idx, 5'b0};
            mem.mem_data_o   = line_w[victim_q];
            if (mem.mem_ack_i) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            mem.mem_enable_o = 1'b1;
            mem.mem_addr_o   = {cpu.cpu_addr_i[31:5], 5'b0};
            if (mem.mem_ack_i) begin
               fill    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         victim_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a bench-side memory answers each transaction after a chosen delay.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i;
   dcache_cpu_if cpu ();
   dcache_mem_if mem ();

   dcache_ctrl dut (.clk_i(clk_i), .rst_i(rst_i), .cpu(cpu.slave), .mem(mem.master));

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int n_wb, n_rd, gaps;
   logic wb_first;
   logic [31:0] wb_addr, rd_addr;
   logic [LINE_BITS-1:0] wb_line;

   function automatic logic [LINE_BITS-1:0] line_of(input logic [31:0] a);
      logic [LINE_BITS-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hC0DE_0000 ^ {a[31:5], i[2:0], 2'b00};
      return l;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [LINE_BITS-1:0] l;
      l = line_of(a);
      return l[a[4:2]*32 +: 32];
   endfunction

   assign mem.mem_data_i = line_of(mem.mem_addr_o);

   // presents one access, acks write-back after a_wb and refill after a_rd enabled cycles
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int a_wb, input int a_rd, output int nstall, output logic [31:0] rd);
      int c_wb, c_rd;
      c_wb = 0; c_rd = 0; nstall = 0; rd = '0;
      n_wb = 0; n_rd = 0; gaps = 0; wb_first = 1'b0; wb_addr = '0; rd_addr = '0; wb_line = '0;
      @(posedge clk_i); #1;
      cpu.cpu_req_i = 1'b1; cpu.cpu_we_i = we; cpu.cpu_addr_i = addr; cpu.cpu_data_i = wd;
      forever begin
         @(negedge clk_i);
         mem.mem_ack_i = 1'b0;
         if (!cpu.cpu_stall_o) begin
            rd = cpu.cpu_data_o;
            break;
         end
         if (nstall > 0 && !mem.mem_enable_o) gaps++;
         nstall++;
         if (mem.mem_enable_o && mem.mem_write_o) begin
            c_wb++;
            if (c_wb == a_wb) begin
               n_wb++; wb_addr = mem.mem_addr_o; wb_line = mem.mem_data_o; wb_first = (n_rd == 0);
               mem.mem_ack_i = 1'b1;
            end
         end else if (mem.mem_enable_o) begin
            c_rd++;
            if (c_rd == a_rd) begin
               n_rd++; rd_addr = mem.mem_addr_o;
               mem.mem_ack_i = 1'b1;
            end
         end
         if (nstall > 300) begin
            checks++; errors++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, nstall);
            break;
         end
      end
      @(posedge clk_i); #1;
      cpu.cpu_req_i = 1'b0; mem.mem_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cpu.cpu_req_i = 1'b0; cpu.cpu_we_i = 1'b0; cpu.cpu_addr_i = '0; cpu.cpu_data_i = '0;
      mem.mem_ack_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++; if (mem.mem_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", mem.mem_enable_o); end
      checks++; if (mem.mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", mem.mem_write_o); end
      checks++; if (mem.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem.mem_addr_o); end
      checks++; if (mem.mem_data_o !== '0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", mem.mem_data_o); end
      checks++; if (cpu.cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_data: got %h want 0", cpu.cpu_data_o); end
      checks++; if (cpu.cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu.cpu_stall_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_cold_load();
      int ns; logic [31:0] rd;
      do_access(1'b0, 32'h0000_0104, '0, 0, 10, ns, rd);
      checks++; if (ns + 1 != 12) begin errors++; $display("FAIL cold_latency: got %0d want 12", ns + 1); end
      checks++; if (n_rd != 1 || n_wb != 0) begin errors++; $display("FAIL cold_txn_count: got rd %0d wb %0d want 1 0", n_rd, n_wb); end
      checks++; if (rd_addr !== 32'h100) begin errors++; $display("FAIL cold_rd_addr: got %h want 00000100", rd_addr); end
      checks++; if (rd !== word_of(32'h104)) begin errors++; $display("FAIL cold_data: got %h want %h", rd, word_of(32'h104)); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL cold_enable_gap: got %0d want 0", gaps); end
   endtask

   task automatic test_store_hit();
      int ns; logic [31:0] rd;
      do_access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1, ns, rd);
      checks++; if (ns != 0) begin errors++; $display("FAIL store_hit_stall: got %0d want 0", ns); end
      do_access(1'b0, 32'h0000_0104, '0, 0, 1, ns, rd);
      checks++; if (ns != 0) begin errors++; $display("FAIL load_hit_stall: got %0d want 0", ns); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_hit_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_dirty_evict();
      int ns; logic [31:0] rd; logic [LINE_BITS-1:0] exp;
      do_access(1'b0, 32'h0000_2104, '0, 0, 3, ns, rd);
      checks++; if (ns + 1 != 5 || n_wb != 0) begin errors++; $display("FAIL fill_way1: got latency %0d wb %0d want 5 0", ns + 1, n_wb); end
      checks++; if (rd !== word_of(32'h2104)) begin errors++; $display("FAIL fill_way1_data: got %h want %h", rd, word_of(32'h2104)); end
      do_access(1'b0, 32'h0000_4104, '0, 4, 5, ns, rd);
      exp = line_of(32'h100);
      exp[63:32] = 32'hDEAD_BEEF;
      checks++; if (n_wb != 1 || !wb_first) begin errors++; $display("FAIL evict_wb_order: got wb %0d first %b want 1 1", n_wb, wb_first); end
      checks++; if (wb_addr !== 32'h100) begin errors++; $display("FAIL evict_wb_addr: got %h want 00000100", wb_addr); end
      checks++; if (wb_line !== exp) begin errors++; $display("FAIL evict_wb_line: got %h want %h", wb_line, exp); end
      checks++; if (n_rd != 1 || rd_addr !== 32'h4100) begin errors++; $display("FAIL evict_rd_addr: got %h count %0d want 00004100 1", rd_addr, n_rd); end
      checks++; if (ns + 1 != 1 + 4 + 5 + 1) begin errors++; $display("FAIL evict_latency: got %0d want 11", ns + 1); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL evict_enable_gap: got %0d want 0", gaps); end
      checks++; if (rd !== word_of(32'h4104)) begin errors++; $display("FAIL evict_data: got %h want %h", rd, word_of(32'h4104)); end
   endtask

   task automatic test_store_miss();
      int ns; logic [31:0] rd; logic [LINE_BITS-1:0] exp;
      do_access(1'b1, 32'h0000_6108, 32'h1234_5678, 0, 2, ns, rd);
      checks++; if (n_wb != 0 || n_rd != 1) begin errors++; $display("FAIL smiss_txn: got wb %0d rd %0d want 0 1", n_wb, n_rd); end
      checks++; if (rd_addr !== 32'h6100) begin errors++; $display("FAIL smiss_rd_addr: got %h want 00006100", rd_addr); end
      checks++; if (ns + 1 != 4) begin errors++; $display("FAIL smiss_latency: got %0d want 4", ns + 1); end
      do_access(1'b0, 32'h0000_6108, '0, 0, 1, ns, rd);
      checks++; if (ns != 0 || rd !== 32'h1234_5678) begin errors++; $display("FAIL smiss_merged: got %h stall %0d want 12345678 0", rd, ns); end
      do_access(1'b0, 32'h0000_6104, '0, 0, 1, ns, rd);
      checks++; if (rd !== word_of(32'h6104)) begin errors++; $display("FAIL smiss_other_word: got %h want %h", rd, word_of(32'h6104)); end
      do_access(1'b0, 32'h0000_8100, '0, 2, 2, ns, rd);
      checks++; if (n_wb != 0) begin errors++; $display("FAIL clean_victim_wb: got %0d want 0", n_wb); end
      do_access(1'b0, 32'h0000_A100, '0, 2, 2, ns, rd);
      exp = line_of(32'h6100);
      exp[95:64] = 32'h1234_5678;
      checks++; if (n_wb != 1 || wb_addr !== 32'h6100) begin errors++; $display("FAIL smiss_dirty_wb: got %h count %0d want 00006100 1", wb_addr, n_wb); end
      checks++; if (wb_line !== exp) begin errors++; $display("FAIL smiss_wb_line: got %h want %h", wb_line, exp); end
   endtask

   task automatic test_reset_mid();
      int ns, guard; logic [31:0] rd;
      @(posedge clk_i); #1;
      cpu.cpu_req_i = 1'b1; cpu.cpu_we_i = 1'b0; cpu.cpu_addr_i = 32'h0000_C104;
      guard = 0;
      do begin @(negedge clk_i); guard++; end
      while (!(mem.mem_enable_o && !mem.mem_write_o) && guard < 50);
      checks++; if (!(mem.mem_enable_o && !mem.mem_write_o)) begin errors++; $display("FAIL rmid_alloc: got en %b wr %b want 1 0", mem.mem_enable_o, mem.mem_write_o); end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0; cpu.cpu_req_i = 1'b0; mem.mem_ack_i = 1'b1;
      checks++; if (mem.mem_enable_o !== 1'b0) begin errors++; $display("FAIL rmid_enable: got %b want 0", mem.mem_enable_o); end
      @(negedge clk_i);
      mem.mem_ack_i = 1'b0;
      checks++; if (mem.mem_enable_o !== 1'b0 || cpu.cpu_stall_o !== 1'b0) begin errors++; $display("FAIL rmid_late_ack: got en %b stall %b want 0 0", mem.mem_enable_o, cpu.cpu_stall_o); end
      do_access(1'b0, 32'h0000_0104, '0, 1, 1, ns, rd);
      checks++; if (n_rd != 1 || rd_addr !== 32'h100 || n_wb != 0) begin errors++; $display("FAIL rmid_relookup: got rd %0d addr %h wb %0d want 1 00000100 0", n_rd, rd_addr, n_wb); end
      checks++; if (rd !== word_of(32'h104)) begin errors++; $display("FAIL rmid_data: got %h want %h", rd, word_of(32'h104)); end
   endtask

   task automatic test_reset_ack_same();
      int ns, guard; logic [31:0] rd;
      @(posedge clk_i); #1;
      cpu.cpu_req_i = 1'b1; cpu.cpu_we_i = 1'b0; cpu.cpu_addr_i = 32'h0000_E104;
      guard = 0;
      do begin @(negedge clk_i); guard++; end
      while (!(mem.mem_enable_o && !mem.mem_write_o) && guard < 50);
      rst_i = 1'b1; mem.mem_ack_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0; mem.mem_ack_i = 1'b0; cpu.cpu_req_i = 1'b0;
      checks++; if (mem.mem_enable_o !== 1'b0) begin errors++; $display("FAIL rack_enable: got %b want 0", mem.mem_enable_o); end
      do_access(1'b0, 32'h0000_E104, '0, 1, 1, ns, rd);
      checks++; if (n_rd != 1 || ns == 0) begin errors++; $display("FAIL rack_refill_dropped: got rd %0d stall %0d want 1 nonzero", n_rd, ns); end
   endtask

   task automatic test_lru();
      int ns; logic [31:0] rd;
      do_access(1'b0, 32'h0000_0000, '0, 1, 1, ns, rd);
      do_access(1'b0, 32'h0000_0200, '0, 1, 1, ns, rd);
      checks++; if (n_wb != 0 || rd_addr !== 32'h200) begin errors++; $display("FAIL lru_fill: got wb %0d addr %h want 0 00000200", n_wb, rd_addr); end
      do_access(1'b0, 32'h0000_0000, '0, 1, 1, ns, rd);
      checks++; if (ns != 0) begin errors++; $display("FAIL lru_hit0a: got stall %0d want 0", ns); end
      do_access(1'b1, 32'h0000_0204, 32'h0BAD_F00D, 1, 1, ns, rd);
      checks++; if (ns != 0) begin errors++; $display("FAIL lru_hit1: got stall %0d want 0", ns); end
      do_access(1'b0, 32'h0000_0000, '0, 1, 1, ns, rd);
      checks++; if (ns != 0) begin errors++; $display("FAIL lru_hit0b: got stall %0d want 0", ns); end
      do_access(1'b0, 32'h0000_0400, '0, 2, 2, ns, rd);
      checks++; if (n_wb != 1 || wb_addr !== 32'h200) begin errors++; $display("FAIL lru_victim: got wb %0d addr %h want 1 00000200", n_wb, wb_addr); end
      do_access(1'b0, 32'h0000_0000, '0, 1, 1, ns, rd);
      checks++; if (ns != 0) begin errors++; $display("FAIL lru_way0_kept: got stall %0d want 0", ns); end
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_store_hit();
      test_dirty_evict();
      test_store_miss();
      test_reset_mid();
      test_reset_ack_same();
      test_lru();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
